// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX scheduling path.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_PAYLOAD,
    S_PAD
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] PAD_BYTE      = 8'h00;
  localparam int         ETH_MIN_FRAME = 60;

  localparam int NUM_SRC = 2;
  localparam int BYTE_W  = 8;
  localparam int CNT_W   = 11;
  localparam int PRE_W   = 4;

  // Byte counter saturates so runaway frames never wrap into the pad window.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the remembered winner moves only on update_i.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o  = req_i;
    if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
    last_d = last_q;
    if (update_i && (|req_i)) last_d = gnt_o[1];
  end

  // Reset to source 1 so source 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/rmii_tx_scheduler.sv
// Round-robin frame scheduler for two AXI-Stream sources feeding one RMII TX;
// adds preamble/SFD and zero-pads short frames.
module rmii_tx_scheduler
  import eth_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN  = 7,
  parameter int MIN_FRAME_LEN = ETH_MIN_FRAME,
  parameter bit PAD_ENABLE    = 1'b1
) (
  input  logic             clock,
  input  logic             aresetn,
  input  logic [BYTE_W-1:0] s0_axis_tdata,
  input  logic             s0_axis_tvalid,
  output logic             s0_axis_tready,
  input  logic             s0_axis_tlast,
  input  logic [BYTE_W-1:0] s1_axis_tdata,
  input  logic             s1_axis_tvalid,
  output logic             s1_axis_tready,
  input  logic             s1_axis_tlast,
  output logic [BYTE_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [1:0]       grant,
  output logic             busy
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_FRAME_LEN - 1);
  localparam logic [CNT_W:0]   MIN_LEN  = (CNT_W+1)'(MIN_FRAME_LEN);

  logic [NUM_SRC-1:0][BYTE_W-1:0] src_tdata;
  logic [NUM_SRC-1:0]             src_tvalid, src_tlast, src_tready;

  assign src_tdata      = {s1_axis_tdata, s0_axis_tdata};
  assign src_tvalid     = {s1_axis_tvalid, s0_axis_tvalid};
  assign src_tlast      = {s1_axis_tlast, s0_axis_tlast};
  assign s0_axis_tready = src_tready[0];
  assign s1_axis_tready = src_tready[1];

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         arb_gnt;
  logic               arb_update;

  rr_arbiter2 u_arb (
    .clk_i    (clock),
    .rst_ni   (aresetn),
    .req_i    (src_tvalid),
    .update_i (arb_update),
    .gnt_o    (arb_gnt)
  );

  logic              sel;
  logic [BYTE_W-1:0] g_tdata;
  logic              g_tvalid, g_tlast;
  logic [CNT_W:0]    cnt_inc;
  logic              pad_needed, pad_last;

  assign sel        = grant_q[1];
  assign g_tdata    = src_tdata[sel];
  assign g_tvalid   = src_tvalid[sel];
  assign g_tlast    = src_tlast[sel];
  // Widened so the compare stays correct when the counter is saturated.
  assign cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign pad_needed = PAD_ENABLE && (cnt_inc < MIN_LEN);
  assign pad_last   = (cnt_q == MIN_LAST);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    pre_cnt_d     = pre_cnt_q;
    cnt_d         = cnt_q;
    arb_update    = 1'b0;
    src_tready    = '0;
    m_axis_tdata  = PAD_BYTE;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|src_tvalid) begin
          arb_update = 1'b1;
          grant_d    = arb_gnt;
          pre_cnt_d  = '0;
          state_d    = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = PREAMBLE_BYTE;
        if (m_axis_tready) begin
          pre_cnt_d = pre_cnt_q + PRE_W'(1);
          if (pre_cnt_q == PRE_LAST) state_d = S_SFD;
        end
      end
      S_SFD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = SFD_BYTE;
        if (m_axis_tready) begin
          cnt_d   = '0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        m_axis_tdata  = g_tdata;
        m_axis_tvalid = g_tvalid;
        m_axis_tlast  = g_tlast && !pad_needed;
        src_tready    = grant_q & {NUM_SRC{m_axis_tready}};
        if (g_tvalid && m_axis_tready) begin
          cnt_d = sat_inc(cnt_q);
          if (g_tlast) begin
            if (pad_needed) begin
              state_d = S_PAD;
            end else begin
              state_d = S_IDLE;
              grant_d = '0;
            end
          end
        end
      end
      S_PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = PAD_BYTE;
        m_axis_tlast  = pad_last;
        if (m_axis_tready) begin
          cnt_d = sat_inc(cnt_q);
          if (pad_last) begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      pre_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_rmii_tx_scheduler.sv
// Directed bench for rmii_tx_scheduler: padded and unpadded instances side by side.
module tb_rmii_tx_scheduler;

  localparam int TMO = 1000;

  logic clock = 1'b0;
  logic aresetn = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] sd [3];
  logic       sv [3];
  logic       sl [3];
  logic       rdy0, rdy1, rdy2, np_rdy1;
  logic       mrdy, np_mrdy;
  logic [7:0] m_tdata, np_tdata;
  logic       m_tvalid, m_tlast, np_tvalid, np_tlast, busy, np_busy;
  logic [1:0] grant, np_grant;

  rmii_tx_scheduler dut (
    .clock(clock), .aresetn(aresetn),
    .s0_axis_tdata(sd[0]), .s0_axis_tvalid(sv[0]), .s0_axis_tready(rdy0), .s0_axis_tlast(sl[0]),
    .s1_axis_tdata(sd[1]), .s1_axis_tvalid(sv[1]), .s1_axis_tready(rdy1), .s1_axis_tlast(sl[1]),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(mrdy), .m_axis_tlast(m_tlast),
    .grant(grant), .busy(busy)
  );

  rmii_tx_scheduler #(.PREAMBLE_LEN(7), .MIN_FRAME_LEN(60), .PAD_ENABLE(1'b0)) dut_np (
    .clock(clock), .aresetn(aresetn),
    .s0_axis_tdata(sd[2]), .s0_axis_tvalid(sv[2]), .s0_axis_tready(rdy2), .s0_axis_tlast(sl[2]),
    .s1_axis_tdata(8'h00), .s1_axis_tvalid(1'b0), .s1_axis_tready(np_rdy1), .s1_axis_tlast(1'b0),
    .m_axis_tdata(np_tdata), .m_axis_tvalid(np_tvalid), .m_axis_tready(np_mrdy), .m_axis_tlast(np_tlast),
    .grant(np_grant), .busy(np_busy)
  );

  int checks = 0;
  int errs   = 0;
  int unstable = 0;
  int xtalk    = 0;
  bit abort_tx = 1'b0;

  logic [8:0] q[$], nq[$], eq[$];
  logic [1:0] gq[$], egq[$];

  logic       pv = 1'b0;
  logic [8:0] pbyte = '0;

  // Output capture, hold-stability and foreign-tready monitors.
  always @(negedge clock) begin
    if (!aresetn) begin
      pv = 1'b0;
    end else begin
      if (pv && m_tvalid && ({m_tlast, m_tdata} !== pbyte)) unstable++;
      if (m_tvalid && mrdy) begin
        q.push_back({m_tlast, m_tdata});
        gq.push_back(grant);
      end
      pv    = m_tvalid && !mrdy;
      pbyte = {m_tlast, m_tdata};
      if ((grant == 2'b01 && rdy1) || (grant == 2'b10 && rdy0) || np_rdy1) xtalk++;
      if (np_tvalid && np_mrdy) nq.push_back({np_tlast, np_tdata});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_of(input int s);
    return (s == 0) ? rdy0 : (s == 1) ? rdy1 : rdy2;
  endfunction

  task automatic send_frame(input int s, input int n, input logic [7:0] base);
    int t;
    for (int i = 0; i < n; i++) begin
      sd[s] = base + 8'(i);
      sv[s] = 1'b1;
      sl[s] = (i == n - 1);
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (!rdy_of(s) && t < TMO && !abort_tx);
      if (abort_tx) begin
        sv[s] = 1'b0;
        sl[s] = 1'b0;
        return;
      end
      if (!rdy_of(s)) begin
        chk($sformatf("handshake_src%0d_byte%0d", s, i), 32'(rdy_of(s)), 32'd1);
        sv[s] = 1'b0;
        sl[s] = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
    sv[s] = 1'b0;
    sl[s] = 1'b0;
  endtask

  // Expected stream: 7 x 55, D5, payload, zero pad up to 60 when enabled.
  task automatic add_exp(input int n, input logic [7:0] base, input bit pad, input logic [1:0] g);
    int total;
    total = (pad && n < 60) ? 60 : n;
    for (int i = 0; i < 7; i++) begin eq.push_back({1'b0, 8'h55}); egq.push_back(g); end
    eq.push_back({1'b0, 8'hD5}); egq.push_back(g);
    for (int i = 0; i < total; i++) begin
      eq.push_back({(i == total - 1), (i < n) ? base + 8'(i) : 8'h00});
      egq.push_back(g);
    end
  endtask

  task automatic clear_all();
    q.delete(); nq.delete(); eq.delete(); gq.delete(); egq.delete();
  endtask

  task automatic wait_idle(input bit np);
    int t = 0;
    while ((np ? np_busy : busy) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk(np ? "np_idle_timeout" : "idle_timeout", 32'(np ? np_busy : busy), 32'd0);
    #1;
  endtask

  task automatic cmp_out(input string tag, input bit np);
    int sz, bad;
    logic [8:0] act, ba, be;
    logic [1:0] ga, gb;
    sz  = np ? nq.size() : q.size();
    chk({tag, "_len"}, 32'(sz), 32'(eq.size()));
    bad = -1; ba = '0; be = '0;
    for (int i = 0; i < sz && i < eq.size(); i++) begin
      act = np ? nq[i] : q[i];
      if (act !== eq[i] && bad < 0) begin bad = i; ba = act; be = eq[i]; end
    end
    chk($sformatf("%s_bytes_at%0d", tag, bad), 32'(ba), 32'(be));
    if (!np) begin
      bad = -1; ga = '0; gb = '0;
      for (int i = 0; i < gq.size() && i < egq.size(); i++)
        if (gq[i] !== egq[i] && bad < 0) begin bad = i; ga = gq[i]; gb = egq[i]; end
      chk($sformatf("%s_grant_at%0d", tag, bad), 32'(ga), 32'(gb));
    end
  endtask

  bit done;

  initial begin
    for (int i = 0; i < 3; i++) begin sd[i] = '0; sv[i] = 1'b0; sl[i] = 1'b0; end
    mrdy = 1'b1; np_mrdy = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_grant",  32'(grant),    0);
    chk("rst_busy",   32'(busy),     0);
    chk("rst_rdy",    32'({rdy0, rdy1}), 0);
    aresetn = 1'b1;
    @(negedge clock);

    // 1: 64-byte frame on s0, no padding, one-cycle latency to preamble
    clear_all();
    fork
      send_frame(0, 64, 8'h10);
      begin
        @(posedge clock); #1;
        chk("c1_lat_busy",  32'(busy), 1);
        chk("c1_lat_tdata", 32'(m_tdata), 32'h55);
        chk("c1_lat_grant", 32'(grant), 32'h1);
        chk("c1_lat_rdy0",  32'(rdy0), 0);
      end
    join
    wait_idle(0);
    add_exp(64, 8'h10, 1'b1, 2'b01);
    cmp_out("c1", 0);
    chk("c1_grant_after", 32'(grant), 0);

    // 2: 10-byte frame on s1, padded to 60
    clear_all();
    send_frame(1, 10, 8'hA0);
    wait_idle(0);
    add_exp(10, 8'hA0, 1'b1, 2'b10);
    cmp_out("c2", 0);

    // 3: both sources continuously valid, two frames each
    clear_all();
    fork
      begin send_frame(0, 60, 8'h00); send_frame(0, 60, 8'h40); end
      begin send_frame(1, 60, 8'h80); send_frame(1, 60, 8'hC0); end
    join
    wait_idle(0);
    add_exp(60, 8'h00, 1'b1, 2'b01);
    add_exp(60, 8'h80, 1'b1, 2'b10);
    add_exp(60, 8'h40, 1'b1, 2'b01);
    add_exp(60, 8'hC0, 1'b1, 2'b10);
    cmp_out("c3", 0);

    // 4: random backpressure on a 20-byte padded frame
    clear_all();
    done = 1'b0;
    fork
      begin send_frame(1, 20, 8'h20); wait_idle(0); done = 1'b1; end
      while (!done) begin
        @(posedge clock); #1;
        mrdy = 1'($urandom_range(0, 1));
      end
    join
    mrdy = 1'b1;
    add_exp(20, 8'h20, 1'b1, 2'b10);
    cmp_out("c4", 0);
    chk("c4_hold_stable", 32'(unstable), 0);

    // 5: reset mid-payload, then a tie after release
    clear_all();
    fork
      send_frame(0, 60, 8'h30);
      begin
        int t = 0;
        while (q.size() < 38 && t < 2000) begin @(negedge clock); t++; end
        chk("c5_reached_payload", 32'(q.size() >= 38), 1);
        aresetn = 1'b0;
        #1;
        chk("c5_tvalid", 32'(m_tvalid), 0);
        chk("c5_grant",  32'(grant), 0);
        chk("c5_busy",   32'(busy), 0);
        chk("c5_rdy",    32'({rdy0, rdy1}), 0);
        abort_tx = 1'b1;
      end
    join
    abort_tx = 1'b0;
    @(negedge clock);
    aresetn = 1'b1;
    @(negedge clock);
    clear_all();
    fork
      send_frame(1, 8, 8'h60);
      send_frame(0, 8, 8'h70);
    join
    wait_idle(0);
    add_exp(8, 8'h70, 1'b1, 2'b01);
    add_exp(8, 8'h60, 1'b1, 2'b10);
    cmp_out("c5_tie", 0);

    // 6: padding disabled, 5-byte frame
    clear_all();
    send_frame(2, 5, 8'hE0);
    wait_idle(1);
    add_exp(5, 8'hE0, 1'b0, 2'b01);
    cmp_out("c6", 1);

    chk("foreign_tready", 32'(xtalk), 0);
    chk("hold_stable_all", 32'(unstable), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
